// File: rtl/fft_r2sdf_stage5.sv
// Last radix-2 SDF stage of the 32-point FFT: 2-point butterflies on adjacent sample pairs,
// emitting sum then difference, each tagged with its bit-reversed natural bin index.
module fft_r2sdf_stage5 #(
    parameter int unsigned DW_IN  = 17,
    parameter int unsigned DW_OUT = 18,
    parameter int unsigned N      = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  logic signed [DW_IN-1:0]  in_r,
    input  logic signed [DW_IN-1:0]  in_i,
    output logic                     out_valid,
    output logic signed [DW_OUT-1:0] out_r,
    output logic signed [DW_OUT-1:0] out_i,
    output logic [4:0]               out_idx,
    output logic                     frame_done
);

    localparam int unsigned CW = $clog2(N);

    typedef enum logic [1:0] {StIdle, StEven, StOdd} state_e;

    function automatic logic [CW-1:0] bitrev(input logic [CW-1:0] v);
        logic [CW-1:0] r;
        for (int k = 0; k < CW; k++) begin
            r[k] = v[CW-1-k];
        end
        return r;
    endfunction

    state_e                    state_q, state_d;
    logic [CW-1:0]             cnt_q, cnt_d;
    logic [CW-2:0]             pair_q, pair_d;
    logic signed [DW_OUT-1:0]  hold_r_q, hold_r_d, hold_i_q, hold_i_d;
    logic signed [DW_OUT-1:0]  diff_r_q, diff_r_d, diff_i_q, diff_i_d;
    logic                      pend_q, pend_d;
    logic                      out_valid_q, out_valid_d;
    logic signed [DW_OUT-1:0]  out_r_q, out_r_d, out_i_q, out_i_d;
    logic [CW-1:0]             out_idx_q, out_idx_d;
    logic                      frame_done_q, frame_done_d;
    logic signed [DW_OUT-1:0]  in_r_ext, in_i_ext;

    assign in_r_ext = {{(DW_OUT-DW_IN){in_r[DW_IN-1]}}, in_r};
    assign in_i_ext = {{(DW_OUT-DW_IN){in_i[DW_IN-1]}}, in_i};

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        pair_d       = pair_q;
        hold_r_d     = hold_r_q;
        hold_i_d     = hold_i_q;
        diff_r_d     = diff_r_q;
        diff_i_d     = diff_i_q;
        pend_d       = pend_q;
        out_valid_d  = 1'b0;
        out_r_d      = out_r_q;
        out_i_d      = out_i_q;
        out_idx_d    = out_idx_q;
        frame_done_d = 1'b0;

        // The pending difference never collides with a sum: after an odd accept the FSM is even.
        if (pend_q) begin
            out_r_d      = diff_r_q;
            out_i_d      = diff_i_q;
            out_idx_d    = bitrev({pair_q, 1'b1});
            out_valid_d  = 1'b1;
            frame_done_d = &pair_q;
            pend_d       = 1'b0;
        end

        if (in_valid) begin
            cnt_d = cnt_q + CW'(1);
            unique case (state_q)
                StIdle, StEven: begin
                    hold_r_d = in_r_ext;
                    hold_i_d = in_i_ext;
                    state_d  = StOdd;
                end
                StOdd: begin
                    out_r_d     = hold_r_q + in_r_ext;
                    out_i_d     = hold_i_q + in_i_ext;
                    out_idx_d   = bitrev({cnt_q[CW-1:1], 1'b0});
                    out_valid_d = 1'b1;
                    diff_r_d    = hold_r_q - in_r_ext;
                    diff_i_d    = hold_i_q - in_i_ext;
                    pair_d      = cnt_q[CW-1:1];
                    pend_d      = 1'b1;
                    state_d     = StEven;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            pair_q       <= '0;
            hold_r_q     <= '0;
            hold_i_q     <= '0;
            diff_r_q     <= '0;
            diff_i_q     <= '0;
            pend_q       <= 1'b0;
            out_valid_q  <= 1'b0;
            out_r_q      <= '0;
            out_i_q      <= '0;
            out_idx_q    <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            pair_q       <= pair_d;
            hold_r_q     <= hold_r_d;
            hold_i_q     <= hold_i_d;
            diff_r_q     <= diff_r_d;
            diff_i_q     <= diff_i_d;
            pend_q       <= pend_d;
            out_valid_q  <= out_valid_d;
            out_r_q      <= out_r_d;
            out_i_q      <= out_i_d;
            out_idx_q    <= out_idx_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_r      = out_r_q;
    assign out_i      = out_i_q;
    assign out_idx    = out_idx_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_fft_r2sdf_stage5.sv
// Directed bench for fft_r2sdf_stage5: reset, single pairs, extremes, gaps, two ramp frames and
// mid-pair reset, all against hand-computed values or a small butterfly model.
module tb_fft_r2sdf_stage5;

    localparam int unsigned DW_IN  = 17;
    localparam int unsigned DW_OUT = 18;

    logic                     clk;
    logic                     rst_n;
    logic                     in_valid;
    logic signed [DW_IN-1:0]  in_r;
    logic signed [DW_IN-1:0]  in_i;
    logic                     out_valid;
    logic signed [DW_OUT-1:0] out_r;
    logic signed [DW_OUT-1:0] out_i;
    logic [4:0]               out_idx;
    logic                     frame_done;

    int n_tests = 0;
    int n_fail  = 0;

    fft_r2sdf_stage5 #(
        .DW_IN  (DW_IN),
        .DW_OUT (DW_OUT),
        .N      (32)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_r       (in_r),
        .in_i       (in_i),
        .out_valid  (out_valid),
        .out_r      (out_r),
        .out_i      (out_i),
        .out_idx    (out_idx),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input longint got, input longint exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Drive inputs away from the edge, then sample just after the rising edge.
    task automatic step(input logic rst_val, input logic v, input int r, input int i);
        @(negedge clk);
        rst_n    = rst_val;
        in_valid = v;
        in_r     = r[DW_IN-1:0];
        in_i     = i[DW_IN-1:0];
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input int r, input int i, input int idx,
                             input int fd);
        check({tag, " valid"}, longint'(out_valid), 1);
        check({tag, " re"}, longint'(out_r), longint'(r));
        check({tag, " im"}, longint'(out_i), longint'(i));
        check({tag, " idx"}, longint'(out_idx), longint'(idx));
        check({tag, " done"}, longint'(frame_done), longint'(fd));
    endtask

    function automatic int bitrev5(input int v);
        int r = 0;
        for (int k = 0; k < 5; k++) begin
            if (v[k]) r = r | (1 << (4 - k));
        end
        return r;
    endfunction

    function automatic int ramp_r(input int n);
        return 3 * n - 40;
    endfunction

    function automatic int ramp_i(input int n);
        return 50 - 5 * n;
    endfunction

    initial begin
        int m, p, base, er, ei;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_r     = '0;
        in_i     = '0;

        // 1: reset with in_valid high
        step(1'b0, 1'b1, 123, -45);
        step(1'b0, 1'b1, 77, 9);
        check("rst valid", longint'(out_valid), 0);
        check("rst re", longint'(out_r), 0);
        check("rst im", longint'(out_i), 0);
        check("rst done", longint'(frame_done), 0);
        check("rst idx", longint'(out_idx), 0);

        // 2: one contiguous pair (pair 0)
        step(1'b1, 1'b1, 64, 0);
        check("pair even valid", longint'(out_valid), 0);
        step(1'b1, 1'b1, 32, -64);
        check_out("pair sum", 96, -64, 0, 0);
        step(1'b1, 1'b0, 0, 0);
        check_out("pair diff", 32, 64, 16, 0);
        step(1'b1, 1'b0, 0, 0);
        check("pair idle valid", longint'(out_valid), 0);
        check("pair hold re", longint'(out_r), 32);
        check("pair hold im", longint'(out_i), 64);

        // 3: extreme operands (pair 1)
        step(1'b1, 1'b1, -65536, 65535);
        step(1'b1, 1'b1, -65536, 65535);
        check_out("ext sum", -131072, 131070, 8, 0);
        step(1'b1, 1'b0, 0, 0);
        check_out("ext diff", 0, 0, 24, 0);

        // 4: gaps inside a pair (pair 2)
        step(1'b1, 1'b1, 100, -7);
        check("gap even valid", longint'(out_valid), 0);
        for (int g = 0; g < 3; g++) begin
            step(1'b1, 1'b0, 0, 0);
            check("gap idle valid", longint'(out_valid), 0);
        end
        step(1'b1, 1'b1, -20, 5);
        check_out("gap sum", 80, -2, 4, 0);
        step(1'b1, 1'b0, 0, 0);
        check_out("gap diff", 120, -12, 20, 0);

        // 5: two back-to-back ramp frames from a fresh reset
        step(1'b0, 1'b0, 0, 0);
        for (int k = 0; k <= 64; k++) begin
            if (k < 64) step(1'b1, 1'b1, ramp_r(k), ramp_i(k));
            else        step(1'b1, 1'b0, 0, 0);
            if (k == 0) begin
                check("ramp first valid", longint'(out_valid), 0);
            end else begin
                m    = (k - 1) % 32;
                p    = m / 2;
                base = ((k - 1) / 32) * 32 + 2 * p;
                if (m % 2 == 0) begin
                    er = ramp_r(base) + ramp_r(base + 1);
                    ei = ramp_i(base) + ramp_i(base + 1);
                end else begin
                    er = ramp_r(base) - ramp_r(base + 1);
                    ei = ramp_i(base) - ramp_i(base + 1);
                end
                check_out($sformatf("ramp o%0d", k - 1), er, ei, bitrev5(m), (m == 31) ? 1 : 0);
            end
        end
        step(1'b1, 1'b0, 0, 0);
        check("ramp tail valid", longint'(out_valid), 0);
        check("ramp tail done", longint'(frame_done), 0);

        // 6: reset the cycle after an odd accept drops the difference
        step(1'b1, 1'b1, 10, 10);
        step(1'b1, 1'b1, 4, 2);
        check_out("rst6 sum", 14, 12, 0, 0);
        step(1'b0, 1'b0, 0, 0);
        check("rst6 valid", longint'(out_valid), 0);
        check("rst6 re", longint'(out_r), 0);
        step(1'b1, 1'b0, 0, 0);
        check("rst6 no diff", longint'(out_valid), 0);
        step(1'b1, 1'b1, 7, 1);
        step(1'b1, 1'b1, 3, 3);
        check_out("rst6 new sum", 10, 4, 0, 0);
        step(1'b1, 1'b0, 0, 0);
        check_out("rst6 new diff", 4, -2, 16, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
